// File: rtl/dmem_wbuf.sv
// dmem_wbuf: word-addressed data memory fronted by a small store buffer.
// Stores are queued as {word index, byte mask, data} and retired into the
// array one per idle cycle. They are also retired when a store arrives
// while the buffer is full. Loads read the array and overlay every matching
// pending store from oldest to youngest, so a load always sees program-order data.
// The array is written only by retiring buffer entries.
// Optional feature macro: DMEM_ERR_EN adds data_err and rejects misaligned or
// out-of-range accesses. Without it, data_addr[1:0] is ignored and the word
// index wraps modulo MEM_WORDS.
// No valid/ready handshake: a store or load is accepted in the cycle it is
// presented. The buffer never back-pressures because a store to a full
// buffer retires the oldest entry in the same cycle.
module dmem_wbuf #(
    parameter int MEM_WORDS = 16384,
    parameter int WB_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
`ifdef DMEM_ERR_EN
    output logic        data_err,
`endif
    output logic        wb_full,
    output logic        wb_empty
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem [MEM_WORDS];

    logic [AW-1:0] wb_idx  [WB_DEPTH];
    logic [3:0]    wb_mask [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [AW-1:0] idx;
    logic          is_store;
    logic          is_load;
    logic          is_idle;
    logic          addr_err;
    logic          store_ok;
    logic          enq;
    logic          drain;
    logic [31:0]   rd_word;
    logic          unused_addr_bits;

    assign idx      = data_addr[AW+1:2];
    assign is_store = (data_write != 4'h0);
    assign is_load  = data_read & ~is_store;
    assign is_idle  = ~data_read & ~is_store;

`ifdef DMEM_ERR_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;
    assign addr_err = (data_addr[1:0] != 2'b00) || ({1'b0, data_addr} >= ADDR_LIMIT);
`else
    assign addr_err = 1'b0;
`endif

    // Address bits outside the word index only matter when error checking is built in.
    assign unused_addr_bits = ^{data_addr[31:AW+2], data_addr[1:0]};

    assign store_ok = is_store & ~addr_err;
    assign enq      = store_ok;
    assign wb_full  = (count == CW'(WB_DEPTH));
    assign wb_empty = (count == '0);
    // Retire on idle cycles, or to make room for a store to a full buffer; never while in reset.
    assign drain    = rst & ~wb_empty & (is_idle | (store_ok & wb_full));

    // Queue pointers and occupancy; reset discards every pending entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            count <= count + CW'(enq) - CW'(drain);
        end
    end

    // Entry payload storage at the tail.
    always_ff @(posedge clk) begin
        if (enq) begin
            wb_idx[tail]  <= idx;
            wb_mask[tail] <= data_write;
            wb_data[tail] <= data_in;
        end
    end

    // Retire the oldest entry into the array, honouring its byte mask.
    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_mask[head][b]) mem[wb_idx[head]][8*b +: 8] <= wb_data[head][8*b +: 8];
            end
        end
    end

    // Load data: array word overlaid by matching pending stores, oldest first.
    always_comb begin
        rd_word = mem[idx];
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((CW'(i) < count) && (wb_idx[head + PW'(i)] == idx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_mask[head + PW'(i)][b]) rd_word[8*b +: 8] = wb_data[head + PW'(i)][8*b +: 8];
                end
            end
        end
    end

    // Registered load result, updated only by load cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_out <= '0;
        else if (is_load) data_out <= addr_err ? 32'h0 : rd_word;
    end

`ifdef DMEM_ERR_EN
    // One-cycle error flag for any rejected load or store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_err <= 1'b0;
        else data_err <= (is_store | is_load) & addr_err;
    end
`endif

endmodule

// File: tb/tb_dmem_wbuf.sv
// Bench for dmem_wbuf: a reference memory plus a pending-store queue models
// the buffer. Expected load data is pushed when a load is driven and popped
// when data_out updates.
module tb_dmem_wbuf;

    localparam int MEM_WORDS = 16384;
    localparam int WB_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_read = 1'b0;
    logic [3:0]  data_write = 4'h0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        wb_full;
    logic        wb_empty;
`ifdef DMEM_ERR_EN
    logic        data_err;
`endif

    dmem_wbuf #(.MEM_WORDS(MEM_WORDS), .WB_DEPTH(WB_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .data_read(data_read),
        .data_write(data_write),
        .data_addr(data_addr),
        .data_in(data_in),
        .data_out(data_out),
`ifdef DMEM_ERR_EN
        .data_err(data_err),
`endif
        .wb_full(wb_full),
        .wb_empty(wb_empty)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  idx;
        logic [3:0]  mask;
        logic [31:0] data;
    } ent_t;

    logic [31:0] ref_mem [1024];
    ent_t        pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_out = '0;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [9:0] w);
        logic [31:0] r;
        r = ref_mem[w];
        foreach (pend[i]) begin
            if (pend[i].idx == w)
                for (int b = 0; b < 4; b++)
                    if (pend[i].mask[b]) r[8*b +: 8] = pend[i].data[8*b +: 8];
        end
        return r;
    endfunction

    task automatic commit();
        ent_t e;
        e = pend.pop_front();
        for (int b = 0; b < 4; b++)
            if (e.mask[b]) ref_mem[e.idx][8*b +: 8] = e.data[8*b +: 8];
    endtask

    // One clock cycle of stimulus, model update and output checks.
    task automatic cycle(input logic rd, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din);
        logic err;
        err = 1'b0;
`ifdef DMEM_ERR_EN
        err = (addr[1:0] != 2'b00) || (addr >= 32'(MEM_WORDS * 4));
`endif
        data_read  = rd;
        data_write = we;
        data_addr  = addr;
        data_in    = din;
        if (we != 4'h0) begin
            if (!err) begin
                if (pend.size() == WB_DEPTH) commit();
                pend.push_back('{addr[11:2], we, din});
            end
        end else if (rd) begin
            exp_q.push_back(err ? 32'h0 : model_read(addr[11:2]));
        end else if (pend.size() > 0) begin
            commit();
        end
        @(posedge clk);
        #1;
        if (we == 4'h0 && rd) last_out = exp_q.pop_front();
        check("data_out", data_out, last_out);
        check("wb_full", 32'(wb_full), 32'(pend.size() == WB_DEPTH));
        check("wb_empty", 32'(wb_empty), 32'(pend.size() == 0));
`ifdef DMEM_ERR_EN
        check("data_err", 32'(data_err), 32'((we != 4'h0 || rd) && err));
`endif
        data_read  = 1'b0;
        data_write = 4'h0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [3:0] m, input logic [31:0] d);
        cycle(1'b0, m, addr, d);
    endtask

    task automatic load(input logic [31:0] addr);
        cycle(1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        data_read = 1'b0;
        data_write = 4'h0;
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_empty", 32'(wb_empty), 32'h1);
        @(posedge clk);
        #1;
        pend.delete();
        exp_q.delete();
        last_out = '0;
        check("rst_full", 32'(wb_full), 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();

        // Prefill words 0..15 so every later load hits known data.
        for (int i = 0; i < 16; i++) store(32'(i * 4), 4'hF, $urandom);
        idle(WB_DEPTH);

        // Full-word store, drained, then read back.
        store(32'h100, 4'hF, 32'h11223344);
        idle(3);
        load(32'h100);
        check("basic_load", data_out, 32'h11223344);
        check("basic_empty", 32'(wb_empty), 32'h1);

        // Byte stores forwarded over an older array word.
        store(32'h40, 4'hF, 32'hAABBCCDD);
        idle(1);
        store(32'h40, 4'h1, 32'h000000EE);
        store(32'h40, 4'h2, 32'h0000FF00);
        load(32'h40);
        check("fwd_merge", data_out, 32'hAABBFFEE);
        idle(2);

        // Six back-to-back stores overflow a four-entry buffer via forced drains.
        for (int i = 0; i < 6; i++) begin
            store(32'(i * 4), 4'hF, 32'hC0DE0000 + 32'(i));
            if (i >= 3) check("full_burst", 32'(wb_full), 32'h1);
        end
        idle(4);
        check("burst_empty", 32'(wb_empty), 32'h1);
        for (int i = 0; i < 6; i++) begin
            load(32'(i * 4));
            check("burst_load", data_out, 32'hC0DE0000 + 32'(i));
        end

        // Simultaneous read and store: store wins, data_out holds.
        cycle(1'b1, 4'hF, 32'h8, 32'h5A5A5A5A);
        check("rw_hold", data_out, 32'hC0DE0005);
        idle(1);
        load(32'h8);
        check("rw_store", data_out, 32'h5A5A5A5A);

        // Reset discards pending stores; array keeps older values.
        for (int i = 0; i < 3; i++) store(32'h200 + 32'(i * 4), 4'hF, 32'h600D0000 + 32'(i));
        idle(3);
        for (int i = 0; i < 3; i++) store(32'h200 + 32'(i * 4), 4'hF, 32'hBAD00000 + 32'(i));
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load(32'h200 + 32'(i * 4));
            check("post_rst_load", data_out, 32'h600D0000 + 32'(i));
        end

`ifdef DMEM_ERR_EN
        // Misaligned store is dropped; out-of-range load returns zero.
        store(32'h102, 4'hF, 32'hDEADBEEF);
        check("err_no_enq", 32'(wb_empty), 32'h1);
        load(32'(MEM_WORDS * 4));
        check("err_load", data_out, 32'h0);
`endif

        // Random mix over the prefilled words.
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            a  = 32'($urandom_range(0, 15)) << 2;
            case (op)
                0: store(a, 4'($urandom_range(1, 15)), $urandom);
                1: load(a);
                default: idle(1);
            endcase
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
